// File: rtl/la_host_link.sv
// Host-side stand-in for the logic-analyzer link: sends one command byte over
// 8N1 UART, then collects the dump stream and reports each byte with a strobe.
module la_host_link #(
  parameter int          CLKS_PER_BIT = 417,
  parameter logic [7:0]  CMD_BYTE     = 8'h01,
  parameter logic [15:0] DUMP_BYTES   = 16'd512,
  parameter logic [23:0] TIMEOUT_CLKS = 24'd4800000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic [15:0] byte_count,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_RECV, S_DONE} sess_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  sess_state_t r_state;
  tx_state_t   r_tx_state;
  rx_state_t   r_rx_state;

  logic          r_rx_meta, r_rx_sync, r_rx_prev;
  logic          r_tx, r_busy, r_done, r_timeout;
  logic [CW-1:0] r_tx_cnt, r_rx_cnt;
  logic [2:0]    r_tx_bit, r_rx_bit;
  logic [7:0]    r_tx_shift, r_rx_shift, r_rx_data;
  logic [23:0]   r_idle_cnt;
  logic [15:0]   r_byte_count;
  logic          r_rx_valid, r_frame_err;

  logic w_start_accept, w_tx_done, w_rx_en, w_rx_start_edge;

  assign w_start_accept  = start & ~r_busy;
  assign w_tx_done       = (r_tx_state == T_STOP) && (r_tx_cnt == BIT_LAST);
  assign w_rx_en         = (r_state == S_RECV);
  assign w_rx_start_edge = w_rx_en && (r_rx_state == R_IDLE) && r_rx_prev && !r_rx_sync;

  // r_rx_prev gives the falling-edge detector its previous synchronised sample
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      if (w_start_accept) begin
        r_state <= S_SEND;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          S_SEND: if (w_tx_done) begin
            r_state    <= S_RECV;
            r_idle_cnt <= '0;
          end
          S_RECV: begin
            if (r_byte_count == DUMP_BYTES) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else if (w_rx_start_edge) begin
              r_idle_cnt <= '0;
            end else if (r_idle_cnt == TIMEOUT_CLKS - 24'd1) begin
              r_state   <= S_IDLE;
              r_timeout <= 1'b1;
              r_busy    <= 1'b0;
            end else begin
              r_idle_cnt <= r_idle_cnt + 24'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= T_IDLE;
      r_tx       <= 1'b1;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
    end else if (w_start_accept) begin
      r_tx_state <= T_START;
      r_tx       <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= CMD_BYTE;
    end else begin
      if (r_tx_state != T_IDLE)
        r_tx_cnt <= (r_tx_cnt == BIT_LAST) ? '0 : r_tx_cnt + 1'b1;
      case (r_tx_state)
        T_START: if (r_tx_cnt == BIT_LAST) begin
          r_tx_state <= T_DATA;
          r_tx       <= r_tx_shift[0];
          r_tx_shift <= r_tx_shift >> 1;
        end
        T_DATA: if (r_tx_cnt == BIT_LAST) begin
          if (r_tx_bit == 3'd7) begin
            r_tx_state <= T_STOP;
            r_tx       <= 1'b1;
          end else begin
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_bit   <= r_tx_bit + 3'd1;
          end
        end
        T_STOP: if (r_tx_cnt == BIT_LAST) r_tx_state <= T_IDLE;
        default: r_tx <= 1'b1;
      endcase
    end
  end

  // A bad stop bit returns to R_IDLE with the line still low; the edge
  // detector then needs the line to go high before it can re-arm.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state   <= R_IDLE;
      r_rx_cnt     <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_byte_count <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_start_accept) begin
        r_byte_count <= '0;
        r_frame_err  <= 1'b0;
      end
      if (!w_rx_en) begin
        r_rx_state <= R_IDLE;
      end else begin
        case (r_rx_state)
          R_IDLE: if (w_rx_start_edge) begin
            r_rx_state <= R_START;
            r_rx_cnt   <= '0;
          end
          R_START: begin
            if (r_rx_cnt == HALF_LAST) begin
              r_rx_cnt   <= '0;
              r_rx_bit   <= '0;
              r_rx_state <= r_rx_sync ? R_IDLE : R_DATA;
            end else begin
              r_rx_cnt <= r_rx_cnt + 1'b1;
            end
          end
          R_DATA: begin
            if (r_rx_cnt == BIT_LAST) begin
              r_rx_cnt   <= '0;
              r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
              if (r_rx_bit == 3'd7) r_rx_state <= R_STOP;
              else                  r_rx_bit   <= r_rx_bit + 3'd1;
            end else begin
              r_rx_cnt <= r_rx_cnt + 1'b1;
            end
          end
          R_STOP: begin
            if (r_rx_cnt == BIT_LAST) begin
              r_rx_state <= R_IDLE;
              r_rx_cnt   <= '0;
              if (!r_rx_sync) begin
                r_frame_err <= 1'b1;
              end else if (r_byte_count < DUMP_BYTES) begin
                r_rx_data    <= r_rx_shift;
                r_rx_valid   <= 1'b1;
                r_byte_count <= r_byte_count + 16'd1;
              end
            end else begin
              r_rx_cnt <= r_rx_cnt + 1'b1;
            end
          end
          default: r_rx_state <= R_IDLE;
        endcase
      end
    end
  end

  assign uart_tx    = r_tx;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign byte_count = r_byte_count;
  assign busy       = r_busy;
  assign done       = r_done;
  assign timeout    = r_timeout;
  assign frame_err  = r_frame_err;

endmodule
